// File: rtl/bus_loader.sv
// UART-driven bus initiator: parses W/R/H/G byte commands, issues single-word
// picorv32-style transfers and returns response bytes. Optional macro BUS_LOADER_TIMEOUT_EN adds a bus wait limit.
module bus_loader #(
  parameter logic       HOLD_ON_RESET  = 1'b1,
  parameter logic [7:0] ACK_BYTE       = 8'h2E,
  parameter logic [7:0] ERR_BYTE       = 8'h21,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_drop,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        cpu_hold
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic        is_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [23:0] shreg;
  logic [1:0]  bytes_left;

`ifdef BUS_LOADER_TIMEOUT_EN
  logic [31:0] wait_cnt;
  logic        limit_hit;
  assign limit_hit = (wait_cnt == 32'(TIMEOUT_CYCLES - 1));
  logic unused_cfg;
  assign unused_cfg = 1'b0;
`else
  logic unused_cfg;
  assign unused_cfg = ^{ERR_BYTE, TIMEOUT_CYCLES[0]};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      is_write   <= 1'b0;
      addr       <= 32'd0;
      wdata      <= 32'd0;
      shreg      <= 24'd0;
      bytes_left <= 2'd0;
      mem_valid  <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      mem_wstrb  <= 4'h0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      rx_drop    <= 1'b0;
      cpu_hold   <= HOLD_ON_RESET;
`ifdef BUS_LOADER_TIMEOUT_EN
      wait_cnt   <= 32'd0;
`endif
    end else begin
      // Bytes that arrive while a transfer or response is in flight are lost.
      rx_drop <= rx_valid && (state == BUS || state == RESP);
      case (state)
        IDLE: begin
          if (rx_valid) begin
            case (rx_data)
              8'h57, 8'h52: begin
                is_write <= (rx_data == 8'h57);
                cnt      <= 2'd0;
                state    <= ADDR;
              end
              8'h48, 8'h47: begin
                cpu_hold   <= (rx_data == 8'h48);
                tx_valid   <= 1'b1;
                tx_data    <= ACK_BYTE;
                bytes_left <= 2'd0;
                state      <= RESP;
              end
              default: ;
            endcase
          end
        end
        ADDR: begin
          if (rx_valid) begin
            addr[{cnt, 3'b000} +: 8] <= rx_data;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) state <= is_write ? DATA : BUS;
          end
        end
        DATA: begin
          if (rx_valid) begin
            wdata[{cnt, 3'b000} +: 8] <= rx_data;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) state <= BUS;
          end
        end
        BUS: begin
          if (!mem_valid) begin
            mem_valid <= 1'b1;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wdata <= wdata;
            mem_wstrb <= is_write ? 4'hF : 4'h0;
`ifdef BUS_LOADER_TIMEOUT_EN
            wait_cnt  <= 32'd0;
`endif
          end else if (mem_ready) begin
            mem_valid <= 1'b0;
            tx_valid  <= 1'b1;
            state     <= RESP;
            if (is_write) begin
              tx_data    <= ACK_BYTE;
              bytes_left <= 2'd0;
            end else begin
              tx_data    <= mem_rdata[7:0];
              shreg      <= mem_rdata[31:8];
              bytes_left <= 2'd3;
            end
          end
`ifdef BUS_LOADER_TIMEOUT_EN
          else if (limit_hit) begin
            mem_valid  <= 1'b0;
            tx_valid   <= 1'b1;
            tx_data    <= ERR_BYTE;
            bytes_left <= 2'd0;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
`endif
        end
        RESP: begin
          if (tx_ready) begin
            if (bytes_left == 2'd0) begin
              tx_valid <= 1'b0;
              state    <= IDLE;
            end else begin
              tx_data    <= shreg[7:0];
              shreg      <= {8'h00, shreg[23:8]};
              bytes_left <= bytes_left - 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
